dbg_step_ctrl: RTL and testbench
================================

DBG_STEP_CTRL -- requirements
Module: dbg_step_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 1: core clock-enable cycles per single step (legal 1..255).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on step_req_i and run_i (legal 2..3).
REQ-003 SHALL have port dbg_clk_clk, input, 1: the block's single clock; rising edge.
REQ-004 SHALL have port dbg_reset_reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port step_req_i, input, 1: step request level from the JTAG debug system's dbg_clock output; a rising edge requests one step.
REQ-006 SHALL have port run_i, input, 1: free-run request level.
REQ-007 SHALL have port pc_i, input, 32: core current PC.
REQ-008 SHALL have port wb_en_i, input, 1: core register writeback valid.
REQ-009 SHALL have port wb_rd_i, input, 5: writeback destination index.
REQ-010 SHALL have port wb_data_i, input, 32: writeback data.
REQ-011 SHALL have port cpu_ce_o, output, 1: core clock enable.
REQ-012 SHALL have port halted_o, output, 1: high in HALT.
REQ-013 SHALL have port snap_o, output, 1: one-cycle pulse when the snapshot is published.
REQ-014 SHALL have port dbg_pc_o, output, 32: published PC; feeds dbg_pc.
REQ-015 SHALL have port dbg_regs_o, output, 1024: published x0..x31, with x[i] at bits [32i+31:32i]; feeds dbg_x0..dbg_x31.

Function
REQ-016 SHALL implement FSM states HALT, STEP, SNAP, RUN.
REQ-017 HALT SHALL go to RUN when synced run_i is high; otherwise to STEP on a synced step_req_i rising edge; run SHALL win when both occur, and the step edge SHALL be discarded.
REQ-018 STEP SHALL hold cpu_ce_o high for exactly STEP_CYCLES cycles via a down-counter, then go to SNAP.
REQ-019 RUN SHALL hold cpu_ce_o high continuously and go to SNAP in the cycle after synced run_i goes low.
REQ-020 SNAP SHALL last one cycle with cpu_ce_o=0, copy the shadow PC and registers to dbg_pc_o and dbg_regs_o, pulse snap_o, then go to HALT.
REQ-021 cpu_ce_o SHALL be registered and high only in STEP and RUN.
REQ-022 Latency: cpu_ce_o SHALL first be high SYNC_STAGES+1 rising edges after the first edge that samples step_req_i high.
REQ-023 Step edges arriving in STEP, SNAP or RUN SHALL be ignored, not queued.
REQ-024 When cpu_ce_o, wb_en_i are high and wb_rd_i!=0, the shadow register at wb_rd_i SHALL take wb_data_i at the next edge.
REQ-025 The shadow for x0 SHALL always read 0; writes to rd=0 SHALL be dropped.
REQ-026 Shadow PC SHALL capture pc_i on every cycle with cpu_ce_o high.
REQ-027 Published outputs SHALL change only in SNAP and SHALL stay frozen in HALT, STEP and RUN.

Reset
REQ-028 While dbg_reset_reset_n is low at an edge, the block SHALL enter HALT, and SHALL clear cpu_ce_o, snap_o, synchronizers, edge detector, step counter, shadow file, dbg_pc_o and dbg_regs_o to 0, with halted_o=1.
REQ-029 Reset in STEP or RUN SHALL drop cpu_ce_o at that same edge, with no SNAP.
REQ-030 After reset release, a step_req_i already high SHALL NOT cause a step; a fresh rising edge SHALL be required.

Configuration
REQ-031 With DBG_STEP_CNT_EN defined, output dbg_step_cnt_o[31:0] SHALL exist; it SHALL increment once per completed STEP (on SNAP from STEP), wrap 0xFFFFFFFF->0, and reset to 0.
REQ-032 Without DBG_STEP_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package dbg_pkg SHALL hold XLEN=32, NREGS=32, the FSM state enum, and the register-slice width constant.
REQ-034 Sub-module dbg_sync (SYNC_STAGES flop synchronizer plus rising-edge detect) SHALL be instantiated for step_req_i and run_i.

Verification
REQ-035 Reset, raise step_req_i with wb x5=0xDEADBEEF in the ce cycle, pc_i=0x100 -> cpu_ce_o high 1 cycle at latency 3, snap_o pulse, dbg_regs_o[191:160]=0xDEADBEEF, dbg_pc_o=0x100.
REQ-036 Write rd=0 data 0x12345678 during a step -> dbg_regs_o[31:0] remains 0.
REQ-037 STEP_CYCLES=4, one step edge -> exactly 4 ce cycles; a second edge during STEP yields no extra step.
REQ-038 run_i high 10 cycles with writes to x1 -> ce high throughout, outputs frozen until SNAP, then x1 shows the last write.
REQ-039 Assert reset mid-RUN -> cpu_ce_o 0 next edge, no snap_o, all outputs 0; held-high step_req_i after release -> no step.
REQ-040 With DBG_STEP_CNT_EN, 3 steps -> dbg_step_cnt_o=3; preload near 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared constants and FSM state encoding for the single-step debug controller.
// Optional step counter is enabled by defining DBG_STEP_CNT_EN.
package dbg_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int REG_W = XLEN;            // width of one register slice in the flat register bus
   localparam int CNT_W = 8;               // covers STEP_CYCLES up to 255

   typedef enum logic [1:0] {
      HALT = 2'd0,
      STEP = 2'd1,
      SNAP = 2'd2,
      RUN  = 2'd3
   } dbg_state_e;

endpackage

// File: rtl/dbg_sync.sv
// Multi-flop synchronizer with a registered rising-edge pulse.
// The edge detector only arms after it has seen a genuine low, so a level held high through reset never fires.
module dbg_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] valid_q;
   logic              prev_q;
   logic              armed_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         valid_q <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[STAGES-2:0], d};
         // valid_q marks when the last stage holds a real sample rather than the reset value
         valid_q <= {valid_q[STAGES-2:0], 1'b1};
         prev_q  <= sync_q[STAGES-1];
         armed_q <= armed_q | (valid_q[STAGES-1] & ~sync_q[STAGES-1]);
         rise    <= armed_q & sync_q[STAGES-1] & ~prev_q;
      end
   end

   assign level = sync_q[STAGES-1];

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug single-step / free-run controller: gates the core clock enable and publishes a PC/register snapshot.
// Define DBG_STEP_CNT_EN to add the completed-step counter output dbg_step_cnt_o.
module dbg_step_ctrl
   import dbg_pkg::*;
#(
   parameter int STEP_CYCLES = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   dbg_clk_clk,
   input  logic                   dbg_reset_reset_n,
   input  logic                   step_req_i,
   input  logic                   run_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic                   wb_en_i,
   input  logic [4:0]             wb_rd_i,
   input  logic [XLEN-1:0]        wb_data_i,
   output logic                   cpu_ce_o,
   output logic                   halted_o,
   output logic                   snap_o,
   output logic [XLEN-1:0]        dbg_pc_o,
   output logic [NREGS*XLEN-1:0]  dbg_regs_o,
`ifdef DBG_STEP_CNT_EN
   output logic [XLEN-1:0]        dbg_step_cnt_o,
`endif
   output dbg_state_e             fsm_state
);

   localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);

   logic                   step_lvl;
   logic                   step_rise;
   logic                   run_lvl;
   logic                   run_rise;
   dbg_state_e             state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [NREGS*XLEN-1:0]  shadow_q;
   logic [NREGS*XLEN-1:0]  shadow_nxt;
   logic [XLEN-1:0]        shadow_pc_q;
   logic [XLEN-1:0]        pc_nxt;
   logic                   step_done;

   dbg_sync #(.STAGES(SYNC_STAGES)) u_step_sync (
      .clk   (dbg_clk_clk),
      .rst_n (dbg_reset_reset_n),
      .d     (step_req_i),
      .level (step_lvl),
      .rise  (step_rise)
   );

   dbg_sync #(.STAGES(SYNC_STAGES)) u_run_sync (
      .clk   (dbg_clk_clk),
      .rst_n (dbg_reset_reset_n),
      .d     (run_i),
      .level (run_lvl),
      .rise  (run_rise)
   );

   assign step_done = (state_q == STEP) && (cnt_q == '0);
   assign fsm_state = state_q;

   // Next shadow contents include this cycle's writeback so SNAP publishes the final instruction's result.
   always_comb begin
      shadow_nxt = shadow_q;
      pc_nxt     = shadow_pc_q;
      if (cpu_ce_o) begin
         pc_nxt = pc_i;
         if (wb_en_i && (wb_rd_i != 5'd0)) begin
            shadow_nxt[wb_rd_i*REG_W +: REG_W] = wb_data_i;
         end
      end
   end

   always_ff @(posedge dbg_clk_clk) begin
      if (!dbg_reset_reset_n) begin
         shadow_q    <= '0;
         shadow_pc_q <= '0;
      end else begin
         shadow_q    <= shadow_nxt;
         shadow_pc_q <= pc_nxt;
      end
   end

   always_ff @(posedge dbg_clk_clk) begin
      if (!dbg_reset_reset_n) begin
         state_q    <= HALT;
         cpu_ce_o   <= 1'b0;
         halted_o   <= 1'b1;
         snap_o     <= 1'b0;
         cnt_q      <= '0;
         dbg_pc_o   <= '0;
         dbg_regs_o <= '0;
      end else begin
         snap_o <= 1'b0;
         case (state_q)
            HALT: begin
               if (run_lvl) begin
                  state_q  <= RUN;
                  cpu_ce_o <= 1'b1;
                  halted_o <= 1'b0;
               end else if (step_rise) begin
                  state_q  <= STEP;
                  cpu_ce_o <= 1'b1;
                  halted_o <= 1'b0;
                  cnt_q    <= STEP_LOAD;
               end
            end
            STEP: begin
               if (cnt_q == '0) begin
                  state_q    <= SNAP;
                  cpu_ce_o   <= 1'b0;
                  snap_o     <= 1'b1;
                  dbg_pc_o   <= pc_nxt;
                  dbg_regs_o <= shadow_nxt;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RUN: begin
               if (!run_lvl) begin
                  state_q    <= SNAP;
                  cpu_ce_o   <= 1'b0;
                  snap_o     <= 1'b1;
                  dbg_pc_o   <= pc_nxt;
                  dbg_regs_o <= shadow_nxt;
               end
            end
            SNAP: begin
               state_q  <= HALT;
               halted_o <= 1'b1;
            end
            default: begin
               state_q  <= HALT;
               cpu_ce_o <= 1'b0;
               halted_o <= 1'b1;
            end
         endcase
      end
   end

`ifdef DBG_STEP_CNT_EN
   always_ff @(posedge dbg_clk_clk) begin
      if (!dbg_reset_reset_n) begin
         dbg_step_cnt_o <= '0;
      end else if (step_done) begin
         dbg_step_cnt_o <= dbg_step_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Directed bench for dbg_step_ctrl: one instance with single-cycle steps, one with four-cycle steps.
// The step-counter scenario is compiled only when DBG_STEP_CNT_EN is defined.
module tb_dbg_step_ctrl;
   import dbg_pkg::*;

   logic          clk;
   logic          rst_n;
   logic          step_req;
   logic          run;
   logic [31:0]   pc;
   logic          wb_en;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;

   logic          cpu_ce, halted, snap;
   logic [31:0]   dbg_pc;
   logic [1023:0] dbg_regs;
   dbg_state_e    fsm_state;

   logic          cpu_ce4, halted4, snap4;
   logic [31:0]   dbg_pc4;
   logic [1023:0] dbg_regs4;
   dbg_state_e    fsm_state4;

`ifdef DBG_STEP_CNT_EN
   logic [31:0]   step_cnt, step_cnt4;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   dbg_step_ctrl #(.STEP_CYCLES(1), .SYNC_STAGES(2)) dut (
      .dbg_clk_clk       (clk),
      .dbg_reset_reset_n (rst_n),
      .step_req_i        (step_req),
      .run_i             (run),
      .pc_i              (pc),
      .wb_en_i           (wb_en),
      .wb_rd_i           (wb_rd),
      .wb_data_i         (wb_data),
      .cpu_ce_o          (cpu_ce),
      .halted_o          (halted),
      .snap_o            (snap),
      .dbg_pc_o          (dbg_pc),
      .dbg_regs_o        (dbg_regs),
`ifdef DBG_STEP_CNT_EN
      .dbg_step_cnt_o    (step_cnt),
`endif
      .fsm_state         (fsm_state)
   );

   dbg_step_ctrl #(.STEP_CYCLES(4), .SYNC_STAGES(2)) dut4 (
      .dbg_clk_clk       (clk),
      .dbg_reset_reset_n (rst_n),
      .step_req_i        (step_req),
      .run_i             (run),
      .pc_i              (pc),
      .wb_en_i           (wb_en),
      .wb_rd_i           (wb_rd),
      .wb_data_i         (wb_data),
      .cpu_ce_o          (cpu_ce4),
      .halted_o          (halted4),
      .snap_o            (snap4),
      .dbg_pc_o          (dbg_pc4),
      .dbg_regs_o        (dbg_regs4),
`ifdef DBG_STEP_CNT_EN
      .dbg_step_cnt_o    (step_cnt4),
`endif
      .fsm_state         (fsm_state4)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
      $fatal(1);
   end

   // driver: raise step_req, observe a fixed window, feed writeback during every ce cycle of dut
   task automatic do_step(input logic [31:0] pc_v, input logic [4:0] rd_v, input logic [31:0] data_v,
                          output int first_k, output int ce_n, output int snap_n, output int ce4_n);
      first_k = -1; ce_n = 0; snap_n = 0; ce4_n = 0;
      @(negedge clk);
      pc = pc_v;
      step_req = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (cpu_ce) begin
            if (first_k < 0) first_k = k;
            ce_n++;
            wb_en = 1'b1; wb_rd = rd_v; wb_data = data_v;
         end else begin
            wb_en = 1'b0;
         end
         if (snap) snap_n++;
         if (cpu_ce4) ce4_n++;
      end
      wb_en = 1'b0;
      step_req = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; step_req = 1'b0; run = 1'b0; pc = '0;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b expected 0", cpu_ce); end
      n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %b expected 1", halted); end
      n_cmp++; if (snap !== 1'b0) begin n_fail++; $display("FAIL reset_snap: got %b expected 0", snap); end
      n_cmp++; if (dbg_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", dbg_pc); end
      n_cmp++; if (dbg_regs !== '0) begin n_fail++; $display("FAIL reset_regs: got nonzero expected 0"); end
      n_cmp++; if (fsm_state !== HALT) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, HALT); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_single_step;
      int first_k, ce_n, snap_n, ce4_n;
      do_step(32'h100, 5'd5, 32'hDEADBEEF, first_k, ce_n, snap_n, ce4_n);
      n_cmp++; if (first_k !== 4) begin n_fail++; $display("FAIL step_latency: got %0d expected 4", first_k); end
      n_cmp++; if (ce_n !== 1) begin n_fail++; $display("FAIL step_ce_count: got %0d expected 1", ce_n); end
      n_cmp++; if (snap_n !== 1) begin n_fail++; $display("FAIL step_snap_count: got %0d expected 1", snap_n); end
      n_cmp++; if (dbg_regs[191:160] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL step_x5: got %h expected deadbeef", dbg_regs[191:160]); end
      n_cmp++; if (dbg_pc !== 32'h100) begin n_fail++; $display("FAIL step_pc: got %h expected 100", dbg_pc); end
      n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL step_halted_after: got %b expected 1", halted); end
      n_cmp++; if (ce4_n !== 4) begin n_fail++; $display("FAIL step4_ce_count: got %0d expected 4", ce4_n); end
   endtask

   task automatic test_x0_write;
      int first_k, ce_n, snap_n, ce4_n;
      do_step(32'h200, 5'd0, 32'h12345678, first_k, ce_n, snap_n, ce4_n);
      n_cmp++; if (dbg_regs[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_write: got %h expected 0", dbg_regs[31:0]); end
      n_cmp++; if (dbg_regs[191:160] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL x0_keep_x5: got %h expected deadbeef", dbg_regs[191:160]); end
      n_cmp++; if (dbg_pc !== 32'h200) begin n_fail++; $display("FAIL x0_pc: got %h expected 200", dbg_pc); end
   endtask

   task automatic test_run;
      int ce_n = 0, snap_n = 0, gap = 0, frozen_bad = 0;
      bit ce_ended = 0;
      logic [31:0] last_data = '0, last_pc = '0;
      @(negedge clk);
      run = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (cpu_ce) begin
            ce_n++;
            if (ce_ended) gap = 1;
            if (dbg_pc !== 32'h200 || dbg_regs[63:32] !== 32'h0 || snap) frozen_bad++;
            last_data = 32'h1000_0000 + 32'(k);
            last_pc   = 32'h3000 + 32'(k * 4);
            wb_en = 1'b1; wb_rd = 5'd1; wb_data = last_data; pc = last_pc;
         end else begin
            wb_en = 1'b0;
            if (ce_n > 0) ce_ended = 1;
         end
         if (ce_n == 10) run = 1'b0;
         if (snap) snap_n++;
      end
      n_cmp++; if (ce_n !== 12) begin n_fail++; $display("FAIL run_ce_count: got %0d expected 12", ce_n); end
      n_cmp++; if (gap !== 0) begin n_fail++; $display("FAIL run_ce_gap: got %0d expected 0", gap); end
      n_cmp++; if (frozen_bad !== 0) begin n_fail++; $display("FAIL run_frozen: got %0d changes expected 0", frozen_bad); end
      n_cmp++; if (snap_n !== 1) begin n_fail++; $display("FAIL run_snap_count: got %0d expected 1", snap_n); end
      n_cmp++; if (dbg_regs[63:32] !== last_data) begin n_fail++; $display("FAIL run_x1: got %h expected %h", dbg_regs[63:32], last_data); end
      n_cmp++; if (dbg_pc !== last_pc) begin n_fail++; $display("FAIL run_pc: got %h expected %h", dbg_pc, last_pc); end
      n_cmp++; if (dbg_regs[191:160] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL run_keep_x5: got %h expected deadbeef", dbg_regs[191:160]); end
   endtask

   task automatic test_multi_step;
      int first4 = -1, ce4_n = 0, snap4_n = 0;
      @(negedge clk);
      wb_en = 1'b0;
      step_req = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (cpu_ce4) begin
            if (first4 < 0) begin
               first4 = k;
               step_req = 1'b0;
            end
            ce4_n++;
         end
         if (first4 > 0 && k == first4 + 1) step_req = 1'b1;
         if (snap4) snap4_n++;
      end
      step_req = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if (first4 !== 4) begin n_fail++; $display("FAIL multi_latency: got %0d expected 4", first4); end
      n_cmp++; if (ce4_n !== 4) begin n_fail++; $display("FAIL multi_ce_count: got %0d expected 4", ce4_n); end
      n_cmp++; if (snap4_n !== 1) begin n_fail++; $display("FAIL multi_snap_count: got %0d expected 1", snap4_n); end
   endtask

   task automatic test_run_wins;
      int ce_n = 0, snap_n = 0, bad_step = 0;
      @(negedge clk);
      run = 1'b1;
      step_req = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (cpu_ce) ce_n++;
         if (snap) snap_n++;
         if (fsm_state == STEP) bad_step++;
         if (k == 8) run = 1'b0;
      end
      step_req = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if (ce_n !== 8) begin n_fail++; $display("FAIL runwin_ce_count: got %0d expected 8", ce_n); end
      n_cmp++; if (snap_n !== 1) begin n_fail++; $display("FAIL runwin_snap_count: got %0d expected 1", snap_n); end
      n_cmp++; if (bad_step !== 0) begin n_fail++; $display("FAIL runwin_step_taken: got %0d expected 0", bad_step); end
   endtask

   task automatic test_reset_mid_run;
      int bad = 0;
      int first_k, ce_n, snap_n, ce4_n;
      @(negedge clk);
      run = 1'b1;
      repeat (6) @(negedge clk);
      n_cmp++; if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL midrun_ce_before: got %b expected 1", cpu_ce); end
      rst_n = 1'b0;
      run = 1'b0;
      step_req = 1'b1;
      @(negedge clk);
      n_cmp++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL midrun_ce: got %b expected 0", cpu_ce); end
      n_cmp++; if (snap !== 1'b0) begin n_fail++; $display("FAIL midrun_snap: got %b expected 0", snap); end
      n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL midrun_halted: got %b expected 1", halted); end
      n_cmp++; if (dbg_pc !== 32'h0) begin n_fail++; $display("FAIL midrun_pc: got %h expected 0", dbg_pc); end
      n_cmp++; if (dbg_regs !== '0) begin n_fail++; $display("FAIL midrun_regs: got nonzero expected 0"); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (cpu_ce || snap || cpu_ce4) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL held_step_after_reset: got %0d active cycles expected 0", bad); end
      step_req = 1'b0;
      repeat (6) @(negedge clk);
      do_step(32'h400, 5'd7, 32'hCAFEF00D, first_k, ce_n, snap_n, ce4_n);
      n_cmp++; if (ce_n !== 1) begin n_fail++; $display("FAIL fresh_edge_ce: got %0d expected 1", ce_n); end
      n_cmp++; if (dbg_regs[255:224] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL fresh_edge_x7: got %h expected cafef00d", dbg_regs[255:224]); end
      n_cmp++; if (dbg_regs[191:160] !== 32'h0) begin n_fail++; $display("FAIL reset_cleared_x5: got %h expected 0", dbg_regs[191:160]); end
      n_cmp++; if (dbg_pc !== 32'h400) begin n_fail++; $display("FAIL fresh_edge_pc: got %h expected 400", dbg_pc); end
   endtask

`ifdef DBG_STEP_CNT_EN
   task automatic test_step_count;
      int first_k, ce_n, snap_n, ce4_n;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (step_cnt !== 32'h0) begin n_fail++; $display("FAIL stepcnt_reset: got %0d expected 0", step_cnt); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 3; i++) do_step(32'h500, 5'd2, 32'h55, first_k, ce_n, snap_n, ce4_n);
      n_cmp++; if (step_cnt !== 32'd3) begin n_fail++; $display("FAIL stepcnt_three: got %0d expected 3", step_cnt); end
      n_cmp++; if (step_cnt4 !== 32'd3) begin n_fail++; $display("FAIL stepcnt4_three: got %0d expected 3", step_cnt4); end
   endtask
`endif

   initial begin
      test_reset;
      test_single_step;
      test_x0_write;
      test_run;
      test_multi_step;
      test_run_wins;
      test_reset_mid_run;
`ifdef DBG_STEP_CNT_EN
      test_step_count;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
